mux_rr_arbiter: RTL and testbench
=================================

# mux_rr_arbiter

Round-robin arbiter and sequencer for a shared 4:1 data multiplexer. Four requesters each present a data word and a request. The block grants one requester at a time, drives the mux select, and registers the selected word onto a single output channel. A grant is held for at most MAXHOLD transfers, so no requester can monopolise the channel. The block sits between the requesting sources and the downstream single-port consumer, replacing a free-running select with a scheduled one.

## Interface
- WIDTH, 8, data word width per requester.
- MAXHOLD, 4, maximum transfers per grant; legal range 1..15.

- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  4  request per requester; req[i] high means Din slice i holds a valid word.
- Din  input  4*WIDTH  packed data; slice i is Din[i*WIDTH +: WIDTH].
- grant  output  4  one-hot grant, or all zero; registered.
- Sel  output  2  index of the current or last granted requester; registered.
- busy  output  1  high while a grant is active (state BUSY).
- Dout  output  WIDTH  registered selected word.
- Dvalid  output  1  Dout carries a transferred word this cycle.

## Operation
- State register has two states, IDLE and BUSY. Other registers:
  - gnt_idx[1:0], driven onto Sel.
  - last[1:0], the round-robin pointer.
  - cnt, 4 bits, the beat counter.
- Reset values: state=IDLE, grant=0000, Sel=0, last=3, cnt=0, busy=0, Dout=0, Dvalid=0.
- Arbitration function win(start):
  - Scan req starting at index start and going upward mod 4; the first set bit wins.
  - Every requester is reached within 4 positions.
- IDLE:
  - Dvalid<=0 and Dout holds its value.
  - If req != 0, then gnt_idx<=win(last+1), grant<=onehot, cnt<=0, state<=BUSY.
  - Otherwise stay in IDLE.
- BUSY, with xfer = req[gnt_idx]:
  - If xfer: Dout<=Din slice gnt_idx, Dvalid<=1, cnt<=cnt+1.
  - If not xfer: Dvalid<=0.
- Release from BUSY occurs when either:
  - req[gnt_idx]==0, or
  - xfer and cnt==MAXHOLD-1 (the last allowed beat).
- On release:
  - last<=gnt_idx.
  - If req != 0, regrant on the same edge to win(gnt_idx+1) with cnt<=0. There is no idle bubble.
  - If req == 0, go to IDLE with grant<=0000. Sel keeps its last value.
- Hold expiry with only the same requester pending: it is regranted on the same edge, cnt restarts, and transfers continue with no gap.
- A request dropping while that requester is granted means no transfer that cycle and release on that edge.
- Requests from non-granted requesters never affect Dout.
- Requesters are not required to hold req until granted. The arbiter samples req each cycle only.
- Invariants:
  - grant is one-hot or zero.
  - grant == (1<<Sel) whenever busy=1.
  - busy == (grant != 0).

## Timing
- Latency from req first seen high in IDLE to grant: 1 edge.
- Latency from grant to the first Dvalid: 1 further edge. Total req-to-Dout is 2 cycles.
- Dout/Dvalid at cycle n+1 reflect the req and Din sampled at edge n under grant gnt_idx.
- Back-to-back grants have a zero-cycle switch gap.
- A continuously requesting granted source gets exactly MAXHOLD consecutive Dvalid beats per grant.
- Asynchronous reset mid-burst forces all outputs and registers to their reset values immediately, without waiting for clk.
- After rst deasserts, the first grant goes to the lowest-index requester (pointer last=3).
- Fairness bound: with all four requesting continuously, each requester waits at most 3*MAXHOLD cycles between grants.

## Test plan
- Reset values: assert rst with random req/Din → grant=0000, Sel=0, busy=0, Dout=0, Dvalid=0. Pulse rst asynchronously between clock edges → outputs clear immediately.
- Single requester, MAXHOLD=4: req=0010 held for 10 cycles with Din slice1 = 8'h10, 8'h11, ... and advancing each cycle → grant=0010 at edge 1. Dvalid is continuous from edge 2 for 10 beats with Dout following the slice-1 sequence. cnt restarts every 4 beats with no gap.
- Full contention: req=1111, slice i = 8'hA0+i constant → grants rotate 0,1,2,3,0. Each grant gives 4 beats. Dout shows A0 x4, A1 x4, A2 x4, A3 x4, A0... with no bubbles.
- Early drop: req=0100 plus req=0001. Drop req[2] after 2 beats → exactly 2 beats of slice 2, then grant=0001 on the release edge, then the slice-0 data.
- Pointer fairness: grant requester 3, then let req=1001 → next grant goes to 0, not 3. Subsequently req=1000 only → grant 3 is re-granted.
- Reset mid-burst: assert rst during the 2nd beat of requester 1 → outputs clear. After release with req=1111 → first grant goes to requester 0.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving a shared 4:1 data mux. It grants one requester at a time,
// limits each grant to MAXHOLD beats, and registers the selected word onto Dout.
module mux_rr_arbiter #(
  parameter int WIDTH   = 8,
  parameter int MAXHOLD = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] Din,
  output logic [3:0]         grant,
  output logic [1:0]         Sel,
  output logic               busy,
  output logic [WIDTH-1:0]   Dout,
  output logic               Dvalid
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state;
  logic [1:0] gnt_idx;
  logic [1:0] last;
  logic [3:0] cnt;

  logic       xfer;
  logic       hold_done;
  logic       release_now;
  logic [1:0] scan_start;
  logic [1:0] next_idx;

  // The scan goes from the highest offset down, so the lowest offset from start wins.
  function automatic logic [1:0] win(input logic [1:0] start, input logic [3:0] r);
    logic [1:0] idx;
    win = start;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (r[idx]) win = idx;
    end
  endfunction

  assign xfer        = req[gnt_idx];
  assign hold_done   = (cnt == 4'(MAXHOLD - 1));
  assign release_now = !xfer || hold_done;
  assign scan_start  = (state == IDLE) ? last + 2'd1 : gnt_idx + 2'd1;
  assign next_idx    = win(scan_start, req);

  assign Sel  = gnt_idx;
  assign busy = (state == BUSY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= 4'b0000;
      gnt_idx <= 2'd0;
      last    <= 2'd3;
      cnt     <= 4'd0;
      Dout    <= '0;
      Dvalid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          Dvalid <= 1'b0;
          if (req != 4'b0000) begin
            gnt_idx <= next_idx;
            grant   <= 4'b0001 << next_idx;
            cnt     <= 4'd0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (xfer) begin
            Dout   <= Din[gnt_idx*WIDTH +: WIDTH];
            Dvalid <= 1'b1;
            cnt    <= cnt + 4'd1;
          end else begin
            Dvalid <= 1'b0;
          end
          // Regrant on the release edge itself so back-to-back grants leave no bubble.
          if (release_now) begin
            last <= gnt_idx;
            if (req != 4'b0000) begin
              gnt_idx <= next_idx;
              grant   <= 4'b0001 << next_idx;
              cnt     <= 4'd0;
            end else begin
              grant <= 4'b0000;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: a queue-free behavioural owner/beat model
// is compared every cycle, plus literal expectations for the directed scenarios.
module tb_mux_rr_arbiter;

  localparam int WIDTH   = 8;
  localparam int MAXHOLD = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [3:0]         req = 4'b0000;
  logic [4*WIDTH-1:0] Din = '0;
  logic [3:0]         grant;
  logic [1:0]         Sel;
  logic               busy;
  logic [WIDTH-1:0]   Dout;
  logic               Dvalid;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: who owns the channel, how many beats it has used, who was served last.
  int               owner    = -1;
  int               beats    = 0;
  int               ptr      = 3;
  int               m_sel    = 0;
  logic [WIDTH-1:0] m_dout   = '0;
  logic             m_dvalid = 1'b0;

  mux_rr_arbiter #(.WIDTH(WIDTH), .MAXHOLD(MAXHOLD)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .Din   (Din),
    .grant (grant),
    .Sel   (Sel),
    .busy  (busy),
    .Dout  (Dout),
    .Dvalid(Dvalid)
  );

  always #5 clk = ~clk;

  function automatic int pick(input int start, input logic [3:0] r);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [4*WIDTH-1:0] d);
    req = r;
    Din = d;
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      owner    = -1;
      beats    = 0;
      ptr      = 3;
      m_sel    = 0;
      m_dout   = '0;
      m_dvalid = 1'b0;
    end else if (owner < 0) begin
      m_dvalid = 1'b0;
      if (req != 4'b0000) begin
        owner = pick(ptr + 1, req);
        beats = 0;
        m_sel = owner;
      end
    end else begin
      if (req[owner]) begin
        m_dout   = Din[owner*WIDTH +: WIDTH];
        m_dvalid = 1'b1;
        beats++;
      end else begin
        m_dvalid = 1'b0;
      end
      if (!req[owner] || beats == MAXHOLD) begin
        ptr   = owner;
        owner = pick(owner + 1, req);
        beats = 0;
        if (owner >= 0) m_sel = owner;
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("grant",  32'(grant),  (owner >= 0) ? (32'd1 << owner) : 32'd0);
    checkOutput("Sel",    32'(Sel),    32'(m_sel));
    checkOutput("busy",   32'(busy),   (owner >= 0) ? 32'd1 : 32'd0);
    checkOutput("Dout",   32'(Dout),   32'(m_dout));
    checkOutput("Dvalid", 32'(Dvalid), 32'(m_dvalid));
  end

  initial begin
    logic [4*WIDTH-1:0] d;
    logic [WIDTH-1:0]   e;

    // Reset with random inputs applied
    req = 4'($urandom_range(0, 15));
    Din = $urandom;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("rst_grant",  32'(grant),  32'd0);
    checkOutput("rst_Sel",    32'(Sel),    32'd0);
    checkOutput("rst_busy",   32'(busy),   32'd0);
    checkOutput("rst_Dout",   32'(Dout),   32'd0);
    checkOutput("rst_Dvalid", 32'(Dvalid), 32'd0);
    rst = 1'b0;
    applyStimulus(4'b0000, '0);

    // Single requester: continuous beats across hold expiry
    $display("[TB] single requester");
    for (int i = 0; i <= 10; i++) begin
      d = 32'($urandom);
      d[1*WIDTH +: WIDTH] = 8'h10 + 8'(i);
      applyStimulus(4'b0010, d);
      if (i == 0) begin
        checkOutput("single_grant", 32'(grant), 32'h2);
      end else begin
        checkOutput("single_Dout",   32'(Dout),   32'(8'h10 + 8'(i)));
        checkOutput("single_Dvalid", 32'(Dvalid), 32'd1);
      end
    end
    applyStimulus(4'b0000, '0);
    applyStimulus(4'b0000, '0);

    // Full contention; pointer was left at 1, so rotation starts at 2
    $display("[TB] full contention");
    for (int i = 0; i <= 20; i++) begin
      applyStimulus(4'b1111, {8'hA3, 8'hA2, 8'hA1, 8'hA0});
      if (i == 0) begin
        checkOutput("rr_first_grant", 32'(grant), 32'h4);
      end else begin
        e = 8'hA0 + 8'((2 + (i - 1) / 4) % 4);
        checkOutput("rr_Dout",   32'(Dout),   32'(e));
        checkOutput("rr_Dvalid", 32'(Dvalid), 32'd1);
      end
    end
    applyStimulus(4'b0000, '0);

    // Early drop of requester 2 while requester 0 waits
    $display("[TB] early drop");
    applyStimulus(4'b0100, {8'h00, 8'h22, 8'h00, 8'h55});
    checkOutput("drop_grant2", 32'(grant), 32'h4);
    applyStimulus(4'b0101, {8'h00, 8'h22, 8'h00, 8'h55});
    applyStimulus(4'b0101, {8'h00, 8'h22, 8'h00, 8'h55});
    checkOutput("drop_beat2_Dout", 32'(Dout), 32'h22);
    applyStimulus(4'b0001, {8'h00, 8'h22, 8'h00, 8'h55});
    checkOutput("drop_regrant",  32'(grant),  32'h1);
    checkOutput("drop_nobeat",   32'(Dvalid), 32'd0);
    checkOutput("drop_holdDout", 32'(Dout),   32'h22);
    applyStimulus(4'b0001, {8'h00, 8'h22, 8'h00, 8'h55});
    checkOutput("drop_slice0", 32'(Dout), 32'h55);
    applyStimulus(4'b0000, '0);
    applyStimulus(4'b0000, '0);

    // Pointer fairness around requester 3
    $display("[TB] pointer fairness");
    applyStimulus(4'b1000, {8'h33, 8'h22, 8'h11, 8'h00});
    checkOutput("ptr_grant3", 32'(grant), 32'h8);
    for (int i = 0; i < MAXHOLD; i++) applyStimulus(4'b1001, {8'h33, 8'h22, 8'h11, 8'h00});
    checkOutput("ptr_to0", 32'(grant), 32'h1);
    applyStimulus(4'b1000, {8'h33, 8'h22, 8'h11, 8'h00});
    checkOutput("ptr_back3", 32'(grant), 32'h8);
    checkOutput("ptr_Sel3",  32'(Sel),   32'd3);
    applyStimulus(4'b0000, '0);
    applyStimulus(4'b0000, '0);

    // Randomised traffic checked by the model every cycle
    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(4'($urandom_range(0, 15)), {$urandom});
    end
    applyStimulus(4'b0000, '0);
    applyStimulus(4'b0000, '0);

    // Asynchronous reset in the middle of requester 1's burst
    $display("[TB] reset mid-burst");
    applyStimulus(4'b0010, {8'h00, 8'h00, 8'h77, 8'h00});
    applyStimulus(4'b0010, {8'h00, 8'h00, 8'h77, 8'h00});
    checkOutput("mid_beat1", 32'(Dvalid), 32'd1);
    #1 rst = 1'b1;
    #1;
    checkOutput("async_grant",  32'(grant),  32'd0);
    checkOutput("async_Sel",    32'(Sel),    32'd0);
    checkOutput("async_busy",   32'(busy),   32'd0);
    checkOutput("async_Dout",   32'(Dout),   32'd0);
    checkOutput("async_Dvalid", 32'(Dvalid), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    applyStimulus(4'b1111, {8'hA3, 8'hA2, 8'hA1, 8'hA0});
    checkOutput("post_rst_grant0", 32'(grant), 32'h1);
    applyStimulus(4'b1111, {8'hA3, 8'hA2, 8'hA1, 8'hA0});
    checkOutput("post_rst_Dout", 32'(Dout), 32'hA0);
    applyStimulus(4'b0000, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
